// File: rtl/multiply_and_saturate.sv
// Rescales a narrow signed sample by a constant factor, saturating to the output range.
// Latency: 4 enabled clock edges from input capture to out/out_valid/sat.
// Backpressure: none beyond en; en=0 freezes every register, including outputs and counter.
module multiply_and_saturate #(
    parameter int IN_WIDTH   = 9,
    parameter int OUT_WIDTH  = 12,
    parameter int MULTIPLIER = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        en,
    input  logic                        in_valid,
    input  logic signed [IN_WIDTH-1:0]  in,
    input  logic                        cnt_clr,
    output logic signed [OUT_WIDTH-1:0] out,
    output logic                        out_valid,
    output logic                        sat,
    output logic [CNT_WIDTH-1:0]        sat_count
);

    // Magnitude needs one extra bit so that |-2^(IN_WIDTH-1)| is representable.
    localparam int MW = IN_WIDTH + 1;
    localparam int PW = MW + $clog2(MULTIPLIER + 1);
    // Comparison width: wide enough for both the product and the output limits.
    localparam int CW = ((PW > OUT_WIDTH) ? PW : OUT_WIDTH) + 1;

    localparam logic [PW-1:0]        MULT_K  = PW'(MULTIPLIER);
    localparam logic [CW-1:0]        NEG_LIM = CW'(1) << (OUT_WIDTH - 1);
    localparam logic [CW-1:0]        POS_LIM = NEG_LIM - CW'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    // Stage registers
    logic signed [IN_WIDTH-1:0]  r_s1_dat;
    logic                        r_s1_vld;
    logic                        r_s2_neg;
    logic [MW-1:0]               r_s2_mag;
    logic                        r_s2_vld;
    logic                        r_s3_neg;
    logic [PW-1:0]               r_s3_prod;
    logic                        r_s3_vld;
    logic signed [OUT_WIDTH-1:0] r_out;
    logic                        r_vld;
    logic                        r_sat;
    logic [CNT_WIDTH-1:0]        r_cnt;

    logic [MW-1:0]               w_s1_ext;
    logic [MW-1:0]               w_s1_mag;
    logic [PW-1:0]               w_s2_prod;
    logic [CW-1:0]               w_s3_ext;
    logic                        w_pos_ovf;
    logic                        w_neg_ovf;
    logic                        w_sat;
    logic [OUT_WIDTH-1:0]        w_low;
    logic [OUT_WIDTH-1:0]        w_res;

    assign w_s1_ext  = {r_s1_dat[IN_WIDTH-1], r_s1_dat};
    assign w_s1_mag  = r_s1_dat[IN_WIDTH-1] ? -w_s1_ext : w_s1_ext;
    assign w_s2_prod = {{(PW-MW){1'b0}}, r_s2_mag} * MULT_K;
    assign w_s3_ext  = {{(CW-PW){1'b0}}, r_s3_prod};
    // The negative side reaches one step further: magnitude 2^(OUT_WIDTH-1) is exact.
    assign w_pos_ovf = !r_s3_neg && (w_s3_ext > POS_LIM);
    assign w_neg_ovf = r_s3_neg && (w_s3_ext > NEG_LIM);
    assign w_sat     = w_pos_ovf || w_neg_ovf;
    assign w_low     = w_s3_ext[OUT_WIDTH-1:0];

    // Clip or re-apply the sign; a zero magnitude negates to +0.
    always_comb begin
        w_res = w_low;
        if (w_pos_ovf) begin
            w_res = POS_LIM[OUT_WIDTH-1:0];
        end else if (w_neg_ovf) begin
            w_res = NEG_LIM[OUT_WIDTH-1:0];
        end else if (r_s3_neg) begin
            w_res = -w_low;
        end
    end

    // S1: capture the raw sample and its valid flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_dat <= '0;
            r_s1_vld <= 1'b0;
        end else if (en) begin
            r_s1_dat <= in;
            r_s1_vld <= in_valid;
        end
    end

    // S2: split into sign and magnitude.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s2_neg <= 1'b0;
            r_s2_mag <= '0;
            r_s2_vld <= 1'b0;
        end else if (en) begin
            r_s2_neg <= r_s1_dat[IN_WIDTH-1];
            r_s2_mag <= w_s1_mag;
            r_s2_vld <= r_s1_vld;
        end
    end

    // S3: unsigned scale of the magnitude.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s3_neg  <= 1'b0;
            r_s3_prod <= '0;
            r_s3_vld  <= 1'b0;
        end else if (en) begin
            r_s3_neg  <= r_s2_neg;
            r_s3_prod <= w_s2_prod;
            r_s3_vld  <= r_s2_vld;
        end
    end

    // S4: register the saturated, signed result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out <= '0;
            r_sat <= 1'b0;
            r_vld <= 1'b0;
        end else if (en) begin
            r_out <= w_res;
            r_sat <= w_sat;
            r_vld <= r_s3_vld;
        end
    end

    // Saturation event counter: clear beats increment, and it sticks at all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (en) begin
            if (cnt_clr) begin
                r_cnt <= '0;
            end else if (r_s3_vld && w_sat && (r_cnt != CNT_MAX)) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign out       = r_out;
    assign out_valid = r_vld;
    assign sat       = r_sat;
    assign sat_count = r_cnt;

endmodule
